// File: rtl/bram_logger.sv
// rtl/bram_logger.sv - sample capture logger with single-port BRAM write path and registered readback
module bram_logger #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       log_start,
    input  logic                       log_stop,
    input  logic [BRAM_DATA_WIDTH-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic                       rd_req,
    input  logic [BRAM_ADDR_WIDTH-1:0] rd_addr,
    output logic [BRAM_DATA_WIDTH-1:0] rd_data,
    output logic                       rd_valid,
    output logic [BRAM_ADDR_WIDTH:0]   wr_count,
    output logic                       log_full,
    output logic                       busy,
    output logic                       bram_cs_n,
    output logic                       bram_write_n,
    output logic                       bram_read_n,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0] bram_wdata,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_rdata
);

    localparam int AW = BRAM_ADDR_WIDTH;
    localparam int DW = BRAM_DATA_WIDTH;
    localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOG  = 2'd1,
        FULL = 2'd2,
        READ = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          ret_full_q, ret_full_d;
    logic [1:0]    rd_phase_q, rd_phase_d;
    logic [AW:0]   wr_count_q, wr_count_d;
    logic          log_full_q, log_full_d;
    logic          cs_n_q, cs_n_d;
    logic          write_n_q, write_n_d;
    logic          read_n_q, read_n_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ret_full_q <= 1'b0;
            rd_phase_q <= 2'd0;
            wr_count_q <= '0;
            log_full_q <= 1'b0;
            cs_n_q     <= 1'b1;
            write_n_q  <= 1'b1;
            read_n_q   <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_full_q <= ret_full_d;
            rd_phase_q <= rd_phase_d;
            wr_count_q <= wr_count_d;
            log_full_q <= log_full_d;
            cs_n_q     <= cs_n_d;
            write_n_q  <= write_n_d;
            read_n_q   <= read_n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ret_full_d = ret_full_q;
        rd_phase_d = rd_phase_q;
        wr_count_d = wr_count_q;
        log_full_d = log_full_q;
        cs_n_d     = 1'b1;
        write_n_d  = 1'b1;
        read_n_d   = 1'b1;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        case (state_q)
            IDLE, FULL: begin
                if (log_start) begin
                    wr_count_d = '0;
                    log_full_d = 1'b0;
                    state_d    = LOG;
                end else if (rd_req) begin
                    ret_full_d = (state_q == FULL);
                    rd_phase_d = 2'd0;
                    cs_n_d     = 1'b0;
                    read_n_d   = 1'b0;
                    addr_d     = rd_addr;
                    state_d    = READ;
                end
            end
            LOG: begin
                if (log_stop) begin
                    state_d = IDLE;
                end else if (sample_valid) begin
                    cs_n_d     = 1'b0;
                    write_n_d  = 1'b0;
                    addr_d     = wr_count_q[AW-1:0];
                    wdata_d    = sample_in;
                    wr_count_d = wr_count_q + 1'b1;
                    // The write that fills the last word also closes the capture.
                    if (wr_count_q == LAST_IDX) begin
                        log_full_d = 1'b1;
                        state_d    = FULL;
                    end
                end
            end
            READ: begin
                // Strobe seen by BRAM at phase 0 edge, data registered one edge later,
                // captured here on the third edge after entry.
                rd_phase_d = rd_phase_q + 1'b1;
                if (rd_phase_q == 2'd2) begin
                    rd_data_d  = bram_rdata;
                    rd_valid_d = 1'b1;
                    state_d    = ret_full_q ? FULL : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign wr_count     = wr_count_q;
    assign log_full     = log_full_q;
    assign busy         = (state_q == LOG) || (state_q == READ);
    assign bram_cs_n    = cs_n_q;
    assign bram_write_n = write_n_q;
    assign bram_read_n  = read_n_q;
    assign bram_addr    = addr_q;
    assign bram_wdata   = wdata_q;

endmodule

// File: doc/bram_logger.md
BRAM_LOGGER -- requirements
Module: bram_logger

Interface
REQ-001 Parameter BRAM_ADDR_WIDTH, default 15, sets the BRAM word address width (AW).
REQ-002 Parameter BRAM_DATA_WIDTH, default 16, sets the sample/BRAM word width (DW).
REQ-003 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 log_start  in  1  one-cycle pulse; starts a capture.
REQ-006 log_stop  in  1  one-cycle pulse; ends a capture early.
REQ-007 sample_in  in  DW  sample to log.
REQ-008 sample_valid  in  1  sample_in valid this cycle.
REQ-009 rd_req  in  1  one-cycle readback request.
REQ-010 rd_addr  in  AW  readback word address.
REQ-011 rd_data  out  DW  readback word.
REQ-012 rd_valid  out  1  rd_data valid, one-cycle pulse.
REQ-013 wr_count  out  AW+1  number of words written in the current/last capture.
REQ-014 log_full  out  1  capture stopped because memory is full.
REQ-015 busy  out  1  high in LOG and READ states.
REQ-016 bram_cs_n, bram_write_n, bram_read_n  out  1 each  active-low BRAM strobes.
REQ-017 bram_addr  out  AW; bram_wdata  out  DW; bram_rdata  in  DW (BRAM registered read data, 1-cycle latency).

Function
REQ-018 FSM states SHALL be IDLE, LOG, FULL, READ; all BRAM-side outputs SHALL be registered.
REQ-019 IDLE or FULL + log_start: wr_count<=0, log_full<=0, -> LOG; log_start SHALL win over simultaneous rd_req.
REQ-020 LOG + sample_valid (no log_stop): next cycle cs_n=0, write_n=0, read_n=1, bram_addr=wr_count[AW-1:0], bram_wdata=sample_in; wr_count increments.
REQ-021 LOG cycles without sample_valid: strobes all high, no write.
REQ-022 LOG + log_stop: -> IDLE, wr_count retained; a sample_valid in the same cycle SHALL NOT be written.
REQ-023 When wr_count reaches 2^AW: -> FULL, log_full=1; further samples SHALL be dropped; no address wrap-around.
REQ-024 log_start and rd_req SHALL be ignored while in LOG or READ.
REQ-025 IDLE or FULL + rd_req: -> READ; next cycle cs_n=0, read_n=0, write_n=1, bram_addr=rd_addr, for exactly one cycle.
REQ-026 rd_data SHALL capture bram_rdata two cycles after the read strobe asserts; rd_valid pulses that same cycle; FSM returns to the state it came from (IDLE or FULL).
REQ-027 Total latency: rd_req sampled at edge N -> rd_valid=1 after edge N+3.
REQ-028 rd_addr >= wr_count SHALL still be read (returns stale contents); no error flag.
REQ-029 rd_data SHALL hold its last value while rd_valid=0.
REQ-030 Outside active write/read cycles, bram_cs_n, bram_write_n and bram_read_n SHALL all be 1; write_n and read_n SHALL never be low together.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, all strobes 1, bram_addr=0, bram_wdata=0, rd_data=0, rd_valid=0, wr_count=0, log_full=0, busy=0.
REQ-032 Reset during LOG or READ SHALL abort the operation; no strobe may remain low after rst_n falls; memory contents are not cleared.

Verification
REQ-033 AW=4: log_start, then 5 samples 0x0011..0x0015 with sample_valid -> 5 writes at addrs 0..4 with matching data, wr_count=5, busy=1.
REQ-034 After REQ-033, log_stop, then rd_req rd_addr=3 -> read strobe at addr 3, rd_data=0x0014 with rd_valid after 3 edges, busy low again.
REQ-035 AW=4: 20 consecutive valid samples -> exactly 16 writes (addrs 0..15), log_full=1, wr_count=16, samples 17-20 dropped.
REQ-036 log_stop with sample_valid same cycle after 2 samples -> wr_count=2, third sample not written; log_start with rd_req in IDLE -> LOG entered, no read strobe.
REQ-037 rst_n low mid-capture after 3 writes -> strobes high immediately, wr_count=0, log_full=0, state IDLE; subsequent read of addr 1 returns the pre-reset value.
